othello_turn_controller: RTL and testbench

- Parametrised top-level game sequencer for the board game datapath.
- Runs welcome, init handshake and turn rotation for NUM_PLAYERS players.
- Adds forced passes when a player has no legal move, rejection of illegal moves, game-over detection on consecutive passes, and an optional per-turn timeout.
- Sits between the user-input debounce logic and the init / move-validation controllers.

---
 rtl/othello_turn_controller_if.sv | 27 ++
 rtl/othello_turn_controller.sv | 157 +++++++++++++++
 tb/tb_othello_turn_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/othello_turn_controller_if.sv
// Handshake bundle between the turn controller and the surrounding game datapath.
// master: the turn controller; slave: debounce/init/move/board logic around it.
interface othello_turn_controller_if #(
   parameter int unsigned PW = 3
);
   logic          go;
   logic          init_end;
   logic          ack;
   logic          nack;
   logic          no_valid_move;
   logic          game_end;
   logic          init_start;
   logic          new_move;
   logic [PW-1:0] player;
   logic          pass_event;
   logic          game_over;

   modport master (
      input  go, init_end, ack, nack, no_valid_move, game_end,
      output init_start, new_move, player, pass_event, game_over
   );

   modport slave (
      output go, init_end, ack, nack, no_valid_move, game_end,
      input  init_start, new_move, player, pass_event, game_over
   );
endinterface

// File: rtl/othello_turn_controller.sv
// Game sequencer: welcome, init handshake, turn rotation, forced passes and game-over.
// Optional per-turn timeout enabled by defining MOVE_TIMEOUT_EN.
module othello_turn_controller #(
   parameter int unsigned NUM_PLAYERS    = 2,
   parameter int unsigned PW             = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input logic                        clock,
   input logic                        reset,
   othello_turn_controller_if.master  bus
);

   localparam int unsigned CW = $clog2(NUM_PLAYERS + 1);
   localparam logic [PW-1:0] LastPlayer = PW'(NUM_PLAYERS - 1);
   localparam logic [CW-1:0] PassLimit  = CW'(NUM_PLAYERS);

   typedef enum logic [2:0] {
      StWelc, StInit, StCheck, StWaitGo, StWaitRel, StValid, StOver
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] player_q, player_d;
   logic [CW-1:0] pass_cnt_q, pass_cnt_d;
   logic          go_q;
   logic          init_start_q, init_start_d;
   logic          new_move_q, new_move_d;
   logic          pass_event_q, pass_event_d;
   logic          game_over_q, game_over_d;
   logic          press;
   logic          take_pass;
   logic [CW-1:0] pass_inc;
   logic [PW-1:0] player_next;

`ifdef MOVE_TIMEOUT_EN
   logic [31:0]   tmo_q, tmo_d;
   logic          tmo_expired;
   assign tmo_expired = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`endif

   assign press       = bus.go & ~go_q;
   assign player_next = (player_q == LastPlayer) ? '0 : player_q + 1'b1;
   assign pass_inc    = (pass_cnt_q == PassLimit) ? PassLimit : pass_cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      player_d   = player_q;
      pass_cnt_d = pass_cnt_q;
      take_pass  = 1'b0;
      new_move_d = 1'b0;

      case (state_q)
         StWelc: if (press) state_d = StInit;
         StInit: begin
            if (bus.init_end) begin
               state_d    = StCheck;
               player_d   = '0;
               pass_cnt_d = '0;
            end
         end
         StCheck: begin
            if (bus.game_end)           state_d   = StOver;
            else if (bus.no_valid_move) take_pass = 1'b1;
            else                        state_d   = StWaitGo;
         end
         StWaitGo: begin
            if (bus.game_end)   state_d = StOver;
            else if (press)     state_d = StWaitRel;
`ifdef MOVE_TIMEOUT_EN
            else if (tmo_expired) take_pass = 1'b1;
`endif
         end
         StWaitRel: begin
            if (bus.game_end) begin
               state_d = StOver;
            end else if (!bus.go) begin
               state_d    = StValid;
               new_move_d = 1'b1;
            end
         end
         StValid: begin
            // ack has priority over a simultaneous nack
            if (bus.game_end) begin
               state_d = StOver;
            end else if (bus.ack) begin
               state_d    = StCheck;
               pass_cnt_d = '0;
               player_d   = player_next;
            end else if (bus.nack) begin
               state_d = StWaitGo;
            end
         end
         StOver: begin
            if (press) begin
               state_d  = StWelc;
               player_d = '0;
            end
         end
         default: state_d = StWelc;
      endcase

      // Player advances even on the final pass that ends the game.
      if (take_pass) begin
         pass_cnt_d = pass_inc;
         player_d   = player_next;
         state_d    = (pass_inc == PassLimit) ? StOver : StCheck;
      end

      init_start_d = (state_d == StInit);
      game_over_d  = (state_d == StOver);
      pass_event_d = take_pass;
   end

`ifdef MOVE_TIMEOUT_EN
   always_comb begin
      tmo_d = tmo_q;
      if (state_d == StWaitGo) begin
         tmo_d = (state_q == StWaitGo) ? tmo_q + 32'd1 : 32'd0;
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StWelc;
         player_q     <= '0;
         pass_cnt_q   <= '0;
         go_q         <= 1'b0;
         init_start_q <= 1'b0;
         new_move_q   <= 1'b0;
         pass_event_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         player_q     <= player_d;
         pass_cnt_q   <= pass_cnt_d;
         go_q         <= bus.go;
         init_start_q <= init_start_d;
         new_move_q   <= new_move_d;
         pass_event_q <= pass_event_d;
         game_over_q  <= game_over_d;
      end
   end

`ifdef MOVE_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) tmo_q <= 32'd0;
      else       tmo_q <= tmo_d;
   end
`endif

   assign bus.init_start = init_start_q;
   assign bus.new_move   = new_move_q;
   assign bus.player     = player_q;
   assign bus.pass_event = pass_event_q;
   assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_othello_turn_controller.sv
// Directed bench for othello_turn_controller with three players and a 10-cycle turn timeout.
module tb_othello_turn_controller;

   localparam int unsigned NP = 3;
   localparam int unsigned PWB = 3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   seen;

   othello_turn_controller_if #(.PW(PWB)) bus ();

   othello_turn_controller #(
      .NUM_PLAYERS   (NP),
      .PW            (PWB),
      .TIMEOUT_CYCLES(10)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full turn; ends in S_CHECK on ack or S_WAIT_GO on nack.
   task automatic turn(input bit from_check, input bit use_ack, input int exp_player,
                       input string tag);
      if (from_check) tick();
      bus.go = 1'b1;
      tick();
      chk({tag, " nm_press"}, 32'(bus.new_move), 32'd0);
      bus.go = 1'b0;
      tick();
      chk({tag, " nm_pulse"}, 32'(bus.new_move), 32'd1);
      tick();
      chk({tag, " nm_single"}, 32'(bus.new_move), 32'd0);
      if (use_ack) bus.ack = 1'b1;
      else         bus.nack = 1'b1;
      tick();
      bus.ack  = 1'b0;
      bus.nack = 1'b0;
      chk({tag, " player"}, 32'(bus.player), 32'(exp_player));
   endtask

   task automatic start_game();
      bus.go = 1'b1;
      tick();
      bus.go       = 1'b0;
      bus.init_end = 1'b1;
      tick();
      bus.init_end = 1'b0;
   endtask

   task automatic to_valid();
      tick();
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
      tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " init_start"}, 32'(bus.init_start), 32'd0);
      chk({tag, " new_move"},   32'(bus.new_move),   32'd0);
      chk({tag, " player"},     32'(bus.player),     32'd0);
      chk({tag, " pass_event"}, 32'(bus.pass_event), 32'd0);
      chk({tag, " game_over"},  32'(bus.game_over),  32'd0);
   endtask

   initial begin
      bus.go = 1'b0; bus.init_end = 1'b0; bus.ack = 1'b0; bus.nack = 1'b0;
      bus.no_valid_move = 1'b0; bus.game_end = 1'b0;

      // Reset and init handshake
      repeat (2) tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();
      chk("welc_idle", 32'(bus.init_start), 32'd0);
      bus.go = 1'b1;
      tick();
      chk("init_enter", 32'(bus.init_start), 32'd1);
      bus.go = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("init_hold", 32'(bus.init_start), 32'd1);
      end
      bus.init_end = 1'b1;
      tick();
      bus.init_end = 1'b0;
      chk_all_zero("check_entry");

      // Rotation 0 -> 1 -> 2 -> 0
      turn(1'b1, 1'b1, 1, "t1");
      turn(1'b1, 1'b1, 2, "t2");
      turn(1'b1, 1'b1, 0, "t3");

      // nack keeps player, stray ack in S_WAIT_GO ignored
      turn(1'b1, 1'b0, 0, "nack");
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      chk("stray_ack", 32'(bus.player), 32'd0);
      turn(1'b0, 1'b1, 1, "after_nack");

      // Two passes, ack resets counter, then three passes end the game
      bus.no_valid_move = 1'b1;
      tick();
      chk("pass1_evt", 32'(bus.pass_event), 32'd1);
      chk("pass1_plr", 32'(bus.player), 32'd2);
      tick();
      chk("pass2_plr", 32'(bus.player), 32'd0);
      chk("pass2_ovr", 32'(bus.game_over), 32'd0);
      bus.no_valid_move = 1'b0;
      turn(1'b1, 1'b1, 1, "mid_ack");
      chk("mid_no_pass", 32'(bus.pass_event), 32'd0);
      bus.no_valid_move = 1'b1;
      tick();
      tick();
      chk("pass4_ovr", 32'(bus.game_over), 32'd0);
      chk("pass4_plr", 32'(bus.player), 32'd0);
      tick();
      bus.no_valid_move = 1'b0;
      chk("pass5_evt", 32'(bus.pass_event), 32'd1);
      chk("pass5_ovr", 32'(bus.game_over), 32'd1);
      chk("pass5_plr", 32'(bus.player), 32'd1);
      tick();
      chk("over_hold", 32'(bus.game_over), 32'd1);
      chk("over_evt", 32'(bus.pass_event), 32'd0);
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
      chk("over_exit", 32'(bus.game_over), 32'd0);
      chk("over_plr0", 32'(bus.player), 32'd0);
      tick();

      // ack with game_end in S_VALID: game_end wins
      start_game();
      turn(1'b1, 1'b1, 1, "ge_pre");
      to_valid();
      bus.ack = 1'b1; bus.game_end = 1'b1;
      tick();
      bus.ack = 1'b0; bus.game_end = 1'b0;
      chk("ge_over", 32'(bus.game_over), 32'd1);
      chk("ge_plr", 32'(bus.player), 32'd1);
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
      chk("ge_welc", 32'(bus.game_over), 32'd0);
      chk("ge_plr0", 32'(bus.player), 32'd0);
      tick();

      // Reset in S_VALID with a concurrent ack
      start_game();
      turn(1'b1, 1'b1, 1, "rst_pre");
      to_valid();
      bus.ack = 1'b1; reset = 1'b1;
      tick();
      bus.ack = 1'b0; reset = 1'b0;
      chk_all_zero("mid_reset");
      tick();

      // Turn timeout behaviour
      start_game();
      tick();
      seen = 1'b0;
`ifdef MOVE_TIMEOUT_EN
      repeat (9) begin
         tick();
         if (bus.pass_event) seen = 1'b1;
      end
      chk("tmo_early", 32'(seen), 32'd0);
      tick();
      chk("tmo_evt", 32'(bus.pass_event), 32'd1);
      chk("tmo_plr", 32'(bus.player), 32'd1);
      tick();
      repeat (9) begin
         tick();
         if (bus.pass_event) seen = 1'b1;
      end
      bus.go = 1'b1;
      tick();
      if (bus.pass_event) seen = 1'b1;
      chk("tmo_press_wins", 32'(seen), 32'd0);
      bus.go = 1'b0;
      tick();
      chk("tmo_rel_nm", 32'(bus.new_move), 32'd1);
      chk("tmo_rel_plr", 32'(bus.player), 32'd1);
`else
      repeat (15) begin
         tick();
         if (bus.pass_event) seen = 1'b1;
      end
      chk("no_tmo", 32'(seen), 32'd0);
      chk("no_tmo_plr", 32'(bus.player), 32'd0);
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
      tick();
      chk("no_tmo_nm", 32'(bus.new_move), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
